// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
// Optional subtract support is enabled with SERIAL_ADD_SUB_EN.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa_cell.sv
// Combinational one-bit full adder made of two half adders and an OR.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (
        .a     (a),
        .b     (b),
        .sum   (s1),
        .carry (c1)
    );

    half_adder u_ha1 (
        .a     (s1),
        .b     (cin),
        .sum   (sum),
        .carry (c2)
    );

    assign cout = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder, the building block of the full-adder cell.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder sharing one full-adder cell, LSB first.
// Define SERIAL_ADD_SUB_EN to honour in_sub (A-B via ~B and carry-in 1).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] s_hi;
    logic [WIDTH-1:0] s_nx;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             load;
    logic             step;
    logic             last;
    logic             b_bit;
    logic             cin0;
    logic             fa_sum;
    logic             fa_cout;

`ifdef SERIAL_ADD_SUB_EN
    logic sub_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q <= 1'b0;
        end else if (load) begin
            sub_q <= in_sub;
        end
    end

    assign b_bit = b_sr[0] ^ sub_q;
    assign cin0  = in_sub;
`else
    logic unused_sub;

    assign unused_sub = in_sub;
    assign b_bit      = b_sr[0];
    assign cin0       = 1'b0;
`endif

    fa_cell u_fa (
        .a    (a_sr[0]),
        .b    (b_bit),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last = (cnt == CW'(WIDTH - 1));
    // Sum bits enter at the MSB, so after WIDTH steps bit 0 is oldest.
    assign s_nx = {fa_sum, s_hi};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            s_hi     <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else if (load) begin
            a_sr  <= in_a;
            b_sr  <= in_b;
            cnt   <= '0;
            carry <= cin0;
        end else if (step) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            s_hi  <= s_nx[WIDTH-1:1];
            carry <= fa_cout;
            cnt   <= cnt + 1'b1;
            if (last) begin
                out_sum  <= s_nx;
                out_cout <= fa_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with a queue-based result scoreboard.
module tb_serial_add_ctrl;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_cout;
    logic       busy;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic sub, input logic [7:0] es,
                         input logic ec);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        @(posedge clk);
        exp_q.push_back('{sum: es, cout: ec});
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!out_valid && cyc < 40);
        if (!out_valid) check("valid_timeout", 0, 1);
    endtask

    // Monitor: compares every handshaken result against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("ready_valid_excl", 32'(in_ready && out_valid), 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_sum", 32'(out_sum), 32'(e.sum));
                    check("out_cout", 32'(out_cout), 32'(e.cout));
                end
            end
        end
    end

    initial begin
        int cyc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_sum", 32'(out_sum), 0);
        check("rst_out_cout", 32'(out_cout), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
        check("busy_run", 32'(busy), 1);
        wait_valid(cyc);
        check("latency", 32'(cyc), 8);
        @(posedge clk);
        #1;
        check("drain_in_ready", 32'(in_ready), 1);
        check("drain_out_valid", 32'(out_valid), 0);

        issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        wait_valid(cyc);
        @(posedge clk);
        #1;
        issue(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);
        wait_valid(cyc);
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        issue(8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0);
        wait_valid(cyc);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_out_sum", 32'(out_sum), 32'h0FF);
            check("bp_out_cout", 32'(out_cout), 0);
        end
        out_ready = 1'b1;
        check("bp_in_ready_pre", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        check("bp_in_ready_post", 32'(in_ready), 1);

        issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_a     = 8'hAA;
        in_b     = 8'h55;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(cyc);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("no_extra_valid", 32'(out_valid), 0);
            @(posedge clk);
            #1;
        end

        issue(8'h21, 8'h10, 1'b0, 8'h31, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 1);
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_out_sum", 32'(out_sum), 0);
        check("abort_busy", 32'(busy), 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(8'h03, 8'h04, 1'b0, 8'h07, 1'b0);
        wait_valid(cyc);
        @(posedge clk);
        #1;

`ifdef SERIAL_ADD_SUB_EN
        issue(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0);
        wait_valid(cyc);
        @(posedge clk);
        #1;
        issue(8'h07, 8'h05, 1'b1, 8'h02, 1'b1);
        wait_valid(cyc);
        @(posedge clk);
        #1;
`else
        issue(8'h07, 8'h05, 1'b1, 8'h0C, 1'b0);
        wait_valid(cyc);
        @(posedge clk);
        #1;
`endif

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that time-shares a single one-bit full-adder cell across a WIDTH-bit add. It accepts an operand pair through a valid/ready handshake and feeds the cell one bit per cycle, LSB first, with the carry held in a flop. It returns the WIDTH-bit sum and carry-out through a second valid/ready handshake. It sits between an operand source and a result consumer where area matters more than throughput.

## Interface
Parameters:
- WIDTH, default 8: operand and sum width; legal range is 2 or more.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: operand pair is valid.
- in_ready, output, 1: controller can accept an operand pair.
- in_a, input, WIDTH: operand A.
- in_b, input, WIDTH: operand B.
- in_sub, input, 1: subtract request. Sampled only when SERIAL_ADD_SUB_EN is defined; ignored otherwise.
- out_valid, output, 1: result is valid.
- out_ready, input, 1: consumer accepts the result.
- out_sum, output, WIDTH: sum (or difference).
- out_cout, output, 1: final carry-out.
- busy, output, 1: high in RUN or DONE.

## Operation
The controller is a three-state machine: IDLE, RUN, DONE.

IDLE:
- in_ready = 1.
- When in_valid && in_ready, on that edge:
  - load the operand shift registers with in_a and in_b;
  - clear the bit counter;
  - set the carry flop to 0 (or 1 when subtracting);
  - go to RUN.

RUN:
- in_ready = 0.
- Each cycle the cell adds a_sr[0], b_sr[0] (or ~b_sr[0] when subtracting) and the carry.
- On each edge:
  - the sum bit shifts into the MSB of the sum shift register;
  - the operands shift right;
  - the carry flop updates;
  - the counter increments.
- When the counter equals WIDTH-1 on an edge:
  - the final sum and carry are copied into the out_sum and out_cout registers;
  - go to DONE.

DONE:
- out_valid = 1.
- When out_valid && out_ready, go to IDLE on that edge.
- New operands are not accepted in the same cycle; in_ready rises the following cycle.

Output and boundary rules:
- out_sum and out_cout are registered. They hold the last completed result until the next completion and do not change during RUN.
- in_valid, in_a, in_b and in_sub are don't-care outside IDLE, and changes to them do not disturb an operation in progress.
- The counter is $clog2(WIDTH) bits wide. Carry-out is bit WIDTH of the true sum; any overflow beyond that is not flagged.
- Reset asserted mid-operation aborts immediately and asynchronously:
  - state returns to IDLE;
  - all registers clear;
  - no partial result is presented.

## Timing
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_cout=0, busy=0.
- Operands accepted at edge k leads to out_valid=1 after edge k+WIDTH.
- Throughput is at most one operation per WIDTH+2 cycles (accept, WIDTH RUN cycles, drain).
- If out_ready is already high when out_valid rises, the drain occurs at edge k+WIDTH+1 and in_ready is high after that edge.
- out_valid holds, and out_sum/out_cout stay stable, for as long as out_ready is low.
- in_ready and out_valid are never high together.

## Configuration
Macro: SERIAL_ADD_SUB_EN.
- Defined: in_sub is latched at acceptance. When it is 1, B is inverted bitwise and carry-in is 1, giving A-B mod 2^WIDTH; out_cout=1 means no borrow.
- Undefined: in_sub is ignored, carry-in is always 0, and the block adds only.

## Structure
- Shared package serial_add_pkg:
  - state enum typedef (IDLE, RUN, DONE);
  - default WIDTH localparam.
- One natural sub-module, fa_cell: a combinational one-bit full adder (a, b, cin -> sum, cout) built from two half-adder instances plus an OR gate. It is instantiated once.
- All sequencing, shift registers, the counter and the handshakes live in serial_add_ctrl.

## Test plan
All scenarios use WIDTH=8.
- Basic add: A=0x0F, B=0x01, out_ready held high -> out_sum=0x10, out_cout=0; out_valid asserts exactly 8 cycles after the accept edge.
- Full overflow: A=0xFF, B=0x01 -> out_sum=0x00, out_cout=1. Then A=0xFF, B=0xFF -> out_sum=0xFE, out_cout=1.
- Backpressure: out_ready held low for 5 cycles after out_valid rises -> out_valid, out_sum and out_cout stay stable; in_ready=0 throughout. When out_ready rises, in_ready rises one cycle later.
- Input during RUN: pulse in_valid with A=0xAA, B=0x55 at cycle 3 of RUN -> ignored; the original 0x12+0x34 completes with out_sum=0x46.
- Reset mid-RUN: assert rst_n=0 at RUN cycle 4 -> in_ready=1, out_valid=0, out_sum=0 immediately; a following 0x03+0x04 gives 0x07.
- With SERIAL_ADD_SUB_EN: A=0x05, B=0x07, in_sub=1 -> out_sum=0xFE, out_cout=0. A=0x07, B=0x05 -> out_sum=0x02, out_cout=1.
